// File: rtl/regfile_decoded.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_decoded
//  Purpose  : Parametrised register file with two asynchronous read ports and
//             one synchronous write port. The write port is steered by an
//             ADDR_W:2**ADDR_W enabled decoder generated from ADDR_W.
//             Optional hardwired zero register (highest index) and optional
//             same-cycle write-to-read bypass.
//  Ports    : clk        - rising-edge clock
//             reset_n    - asynchronous active-low reset
//             wr_en      - write enable (gates the decoder)
//             wr_addr    - write register index
//             wr_data    - write data
//             rd_addr_a  - read port A index
//             rd_addr_b  - read port B index
//             rd_data_a  - read port A data (combinational)
//             rd_data_b  - read port B data (combinational)
//             wr_sel     - registered one-hot copy of the last write select
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_decoded #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic [ADDR_W-1:0]      rd_addr_a,
   input  logic [ADDR_W-1:0]      rd_addr_b,
   output logic [DATA_W-1:0]      rd_data_a,
   output logic [DATA_W-1:0]      rd_data_b,
   output logic [(2**ADDR_W)-1:0] wr_sel
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(DEPTH - 1);

   logic [DEPTH-1:0]  sel;
   logic [DATA_W-1:0] regs [DEPTH];

   // Enabled write-select decoder, one comparator per register index.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_dec
         assign sel[i] = wr_en & (wr_addr == ADDR_W'(i));
      end
   endgenerate

   // Storage and trace register. The zero register is never loaded, but its
   // select bit is still captured in wr_sel so the attempted write is visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         wr_sel <= '0;
      end else begin
         wr_sel <= sel;
         for (int i = 0; i < DEPTH; i++) begin
            if (sel[i] && !((ZERO_REG != 0) && (i == DEPTH - 1))) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   // Read port A. Bypass is suppressed while in reset so reads stay 0, and
   // the zero register overrides bypass.
   always_comb begin
      rd_data_a = regs[rd_addr_a];
      if ((BYPASS != 0) && reset_n && wr_en && (rd_addr_a == wr_addr)) begin
         rd_data_a = wr_data;
      end
      if ((ZERO_REG != 0) && (rd_addr_a == ZERO_IDX)) begin
         rd_data_a = '0;
      end
   end

   // Read port B, independent of port A.
   always_comb begin
      rd_data_b = regs[rd_addr_b];
      if ((BYPASS != 0) && reset_n && wr_en && (rd_addr_b == wr_addr)) begin
         rd_data_b = wr_data;
      end
      if ((ZERO_REG != 0) && (rd_addr_b == ZERO_IDX)) begin
         rd_data_b = '0;
      end
   end

endmodule
`default_nettype wire
